pit_wb_arbiter: RTL and testbench

Round-robin WISHBONE arbiter that shares the single PIT register-bus slave port among up to four bus masters, e.g. a CPU and a DMA/sequencer. It sits between the masters and the PIT bus interface. It grants one master at a time for the full duration of its cycle (`cyc`). It routes acknowledge and read data back only to the granted master. An optional watchdog frees the bus if the slave never acknowledges.

---
 rtl/pit_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pit_wb_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_wb_arbiter.sv
// Round-robin WISHBONE arbiter sharing the PIT slave port among 2..4 masters.
// Define PIT_WB_ARB_TIMEOUT_EN to build the no-ack watchdog.
module pit_wb_arbiter #(
    parameter int DWIDTH   = 16,
    parameter int NMASTERS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       arst_i,
    input  logic                       wb_rst_i,
    input  logic [NMASTERS-1:0]        m_cyc_i,
    input  logic [NMASTERS-1:0]        m_stb_i,
    input  logic [NMASTERS-1:0]        m_we_i,
    input  logic [3*NMASTERS-1:0]      m_adr_i,
    input  logic [DWIDTH*NMASTERS-1:0] m_dat_i,
    input  logic [2*NMASTERS-1:0]      m_sel_i,
    output logic [DWIDTH-1:0]          m_dat_o,
    output logic [NMASTERS-1:0]        m_ack_o,
    output logic [NMASTERS-1:0]        m_err_o,
    output logic [NMASTERS-1:0]        grant_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [2:0]                 s_adr_o,
    output logic [DWIDTH-1:0]          s_dat_o,
    output logic [1:0]                 s_sel_o,
    input  logic [DWIDTH-1:0]          s_dat_i,
    input  logic                       s_ack_i
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    localparam logic [1:0] LAST_IX = 2'(NMASTERS - 1);

    if (NMASTERS < 2 || NMASTERS > 4 || TIMEOUT < 2 || TIMEOUT > 255 ||
        (DWIDTH != 8 && DWIDTH != 16)) begin : g_bad_param
        $error("pit_wb_arbiter: illegal parameter value");
    end

    state_e              state_q, state_d;
    logic [NMASTERS-1:0] grant_q, grant_d;
    logic [1:0]          last_q, last_d;

    logic [3:0]          cyc_a, stb_a, we_a;
    logic [2:0]          adr_a [4];
    logic [DWIDTH-1:0]   dat_a [4];
    logic [1:0]          sel_a [4];

    logic [NMASTERS-1:0] pick_oh;
    logic [1:0]          pick_idx;
    logic [1:0]          cand;
    logic                pick_vld;
    logic                in_grant;
    logic                timeout;

    // Pad master fields to four slots so a 2-bit index selects cleanly.
    for (genvar k = 0; k < 4; k++) begin : g_pad
        if (k < NMASTERS) begin : g_on
            assign cyc_a[k] = m_cyc_i[k];
            assign stb_a[k] = m_stb_i[k];
            assign we_a[k]  = m_we_i[k];
            assign adr_a[k] = m_adr_i[3*k +: 3];
            assign dat_a[k] = m_dat_i[DWIDTH*k +: DWIDTH];
            assign sel_a[k] = m_sel_i[2*k +: 2];
            assign pick_oh[k] = (pick_idx == 2'(k));
        end else begin : g_off
            assign cyc_a[k] = 1'b0;
            assign stb_a[k] = 1'b0;
            assign we_a[k]  = 1'b0;
            assign adr_a[k] = '0;
            assign dat_a[k] = '0;
            assign sel_a[k] = '0;
        end
    end

    // Walk last+1, last+2, ... and take the first live request.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        cand     = last_q;
        for (int i = 0; i < NMASTERS; i++) begin
            cand = (cand == LAST_IX) ? 2'd0 : cand + 2'd1;
            if (!pick_vld && cyc_a[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign in_grant = (state_q == ST_GRANT);

`ifdef PIT_WB_ARB_TIMEOUT_EN
    localparam logic [7:0] WD_LIM = 8'(TIMEOUT - 1);

    logic [7:0] wd_q, wd_d;

    assign timeout = in_grant && stb_a[last_q] && !s_ack_i &&
                     (wd_q == WD_LIM);

    always_comb begin
        wd_d = wd_q;
        if (!in_grant || s_ack_i) begin
            wd_d = '0;
        end else if (stb_a[last_q]) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wd_q <= '0;
        end else if (wb_rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign m_err_o = grant_q & {NMASTERS{timeout}};
`else
    assign timeout = 1'b0;
    assign m_err_o = '0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    grant_d = pick_oh;
                    last_d  = pick_idx;
                end
            end
            ST_GRANT: begin
                if (!cyc_a[last_q] || timeout) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_IX;
        end else if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_IX;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // While granted, last_q is the granted index.
    assign grant_o = grant_q;
    assign s_cyc_o = in_grant && cyc_a[last_q] && !timeout;
    assign s_stb_o = in_grant && stb_a[last_q] && !timeout;
    assign s_we_o  = in_grant && we_a[last_q];
    assign s_adr_o = in_grant ? adr_a[last_q] : '0;
    assign s_dat_o = in_grant ? dat_a[last_q] : '0;
    assign s_sel_o = in_grant ? sel_a[last_q] : '0;
    assign m_ack_o = grant_q & {NMASTERS{s_ack_i}};
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_pit_wb_arbiter.sv
// Bench for pit_wb_arbiter: owner/priority model plus directed scenarios.
// Timeout scenario runs only when PIT_WB_ARB_TIMEOUT_EN is defined.
module tb_pit_wb_arbiter;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int TO = 4;
`ifdef PIT_WB_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst;
    logic wb_rst;

    logic          mc [N];
    logic          ms [N];
    logic          mw [N];
    logic [2:0]    ma [N];
    logic [DW-1:0] md [N];
    logic [1:0]    msel [N];

    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [3*N-1:0]  m_adr_i;
    logic [DW*N-1:0] m_dat_i;
    logic [2*N-1:0]  m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [2:0]      s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [1:0]      s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i = 1'b0;

    assign m_cyc_i = {mc[1], mc[0]};
    assign m_stb_i = {ms[1], ms[0]};
    assign m_we_i  = {mw[1], mw[0]};
    assign m_adr_i = {ma[1], ma[0]};
    assign m_dat_i = {md[1], md[0]};
    assign m_sel_i = {msel[1], msel[0]};

    pit_wb_arbiter #(.DWIDTH(DW), .NMASTERS(N), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .arst_i(arst), .wb_rst_i(wb_rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .grant_o(grant_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Wait-state slave: ack in the second cycle of each strobe.
    bit   slave_en = 1'b1;
    logic stb_n = 1'b0;
    logic ack_n = 1'b0;
    always @(negedge clk) begin
        stb_n = s_stb_o;
        ack_n = s_ack_i;
    end
    always @(posedge clk) begin
        #1;
        s_ack_i = slave_en && stb_n && !ack_n;
    end

    // Model: owner is -1 when idle, else the granted master number.
    int owner = -1;
    int last  = N - 1;
    int stall = 0;

    function automatic bit wd_fire();
        if (!WD_EN || owner < 0) return 1'b0;
        return ms[owner] && !s_ack_i && (stall + 1 == TO);
    endfunction

    always @(posedge clk or negedge arst) begin
        if (!arst || wb_rst) begin
            owner = -1;
            last  = N - 1;
            stall = 0;
        end else if (owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (owner < 0 && mc[(last + i) % N]) begin
                    owner = (last + i) % N;
                    stall = 0;
                end
            end
            if (owner >= 0) last = owner;
        end else if (wd_fire() || !mc[owner]) begin
            owner = -1;
        end else if (s_ack_i) begin
            stall = 0;
        end else if (ms[owner]) begin
            stall = stall + 1;
        end
    end

    logic [N-1:0]  eg, eack, eerr;
    logic          ecyc, estb, ewe;
    logic [2:0]    eadr;
    logic [DW-1:0] edat;
    logic [1:0]    esel;
    bit            fire;

    always @(negedge clk) begin
        if (chk_en) begin
            eg = '0; eack = '0; eerr = '0;
            ecyc = 0; estb = 0; ewe = 0;
            eadr = '0; edat = '0; esel = '0;
            if (owner >= 0) begin
                fire = wd_fire();
                eg   = N'(1) << owner;
                ecyc = mc[owner] && !fire;
                estb = ms[owner] && !fire;
                ewe  = mw[owner];
                eadr = ma[owner];
                edat = md[owner];
                esel = msel[owner];
                eack = s_ack_i ? eg : '0;
                eerr = fire ? eg : '0;
            end
            n_chk++;
            if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
                 s_sel_o, m_ack_o, m_err_o, m_dat_o} !==
                {eg, ecyc, estb, ewe, eadr, edat, esel, eack, eerr,
                 s_dat_i}) begin
                n_fail++;
                $display("FAIL model t=%0t got g=%b cyc=%b stb=%b we=%b adr=%0d dat=%h sel=%b ack=%b err=%b rd=%h req g=%b cyc=%b stb=%b we=%b adr=%0d dat=%h sel=%b ack=%b err=%b rd=%h",
                         $time, grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o,
                         s_dat_o, s_sel_o, m_ack_o, m_err_o, m_dat_o,
                         eg, ecyc, estb, ewe, eadr, edat, esel, eack, eerr,
                         s_dat_i);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rst_pulse();
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        tick();
    endtask

    // Hold cyc/stb for n acknowledged transfers, then drop.
    task automatic xfer(input int k, input logic we, input logic [2:0] adr,
                        input logic [DW-1:0] dat, input int n,
                        output logic [DW-1:0] rd, output logic [N-1:0] ackv,
                        output bit ok);
        mc[k] = 1'b1; ms[k] = 1'b1; mw[k] = we;
        ma[k] = adr;  md[k] = dat;  msel[k] = 2'b11;
        ok = 1'b1;
        rd = '0;
        ackv = '0;
        for (int t = 0; t < n; t++) begin
            bit got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (m_ack_o[k]) begin
                    got  = 1'b1;
                    rd   = m_dat_o;
                    ackv = m_ack_o;
                end
            end
            if (!got) ok = 1'b0;
        end
        @(posedge clk);
        #2;
        mc[k] = 1'b0; ms[k] = 1'b0;
    endtask

    logic [N-1:0] gseq [$];

    task automatic watch(input int cycles);
        logic [N-1:0] pv = '0;
        gseq.delete();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (i == 0 || grant_o != pv) begin
                gseq.push_back(grant_o);
                pv = grant_o;
            end
        end
    endtask

    task automatic check_seq(input string nm, input logic [7:0] exp [4]);
        n_chk++;
        if (gseq.size() < 4 || gseq[0] !== exp[0][N-1:0] ||
            gseq[1] !== exp[1][N-1:0] || gseq[2] !== exp[2][N-1:0] ||
            gseq[3] !== exp[3][N-1:0]) begin
            n_fail++;
            $display("FAIL %s: got grant changes %p required %p",
                     nm, gseq, exp);
        end
    endtask

    logic [DW-1:0] rd0, rd1;
    logic [N-1:0]  ak0, ak1;
    bit            ok0, ok1, okw;
    logic [7:0]    seq_c [4];
    logic [7:0]    seq_d [4];

    initial begin
        for (int k = 0; k < N; k++) begin
            mc[k] = 0; ms[k] = 0; mw[k] = 0;
            ma[k] = '0; md[k] = '0; msel[k] = '0;
        end
        arst = 1'b1;
        wb_rst = 1'b0;
        s_dat_i = '0;
        #1 arst = 1'b0;
        chk_en = 1'b1;
        #20;
        check("reset_grant", 32'(grant_o), 0);
        check("reset_s_cyc_stb", 32'({s_cyc_o, s_stb_o}), 0);
        @(posedge clk);
        #2 arst = 1'b1;

        // Async reset in the middle of a granted cycle.
        mc[0] = 1; ms[0] = 1;
        tick();
        check("pre_arst_grant", 32'(grant_o), 32'h1);
        #1 arst = 1'b0;
        #1;
        check("arst_grant", 32'(grant_o), 0);
        check("arst_outputs", 32'({s_cyc_o, s_stb_o, m_ack_o, m_err_o}), 0);
        mc[0] = 0; ms[0] = 0;
        tick();
        mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
        arst = 1'b1;
        tick();
        check("first_after_arst", 32'(grant_o), 32'h1);
        mc[0] = 0; ms[0] = 0; mc[1] = 0; ms[1] = 0;
        repeat (3) tick();

        // Single write from master 0.
        rst_pulse();
        ma[0] = 3'd1; md[0] = 16'h1234; mw[0] = 1; msel[0] = 2'b11;
        mc[0] = 1; ms[0] = 1;
        tick();
        check("wr_grant", 32'(grant_o), 32'h1);
        check("wr_adr", 32'(s_adr_o), 32'h1);
        check("wr_dat", 32'(s_dat_o), 32'h1234);
        check("wr_ack_first", 32'(m_ack_o), 0);
        tick();
        check("wr_ack", 32'(m_ack_o), 32'h1);
        tick();
        mc[0] = 0; ms[0] = 0;
        check("wr_ack_one_cycle", 32'(m_ack_o), 0);
        repeat (3) tick();

        // Both masters contend with single-transfer cycles.
        rst_pulse();
        s_dat_i = 16'hBEEF;
        fork
            begin
                xfer(0, 1'b1, 3'd3, 16'h00A5, 1, rd0, ak0, ok0);
                tick();
                xfer(0, 1'b1, 3'd4, 16'h5A00, 1, rd0, ak0, okw);
                ok0 = ok0 && okw;
            end
            xfer(1, 1'b0, 3'd2, 16'h0000, 1, rd1, ak1, ok1);
            watch(20);
        join
        check("rr_m0_done", 32'(ok0), 1);
        check("rr_m1_done", 32'(ok1), 1);
        check("rr_read_data", 32'(rd1), 32'hBEEF);
        check("rr_read_ack", 32'(ak1), 32'h2);
        seq_c = '{8'h1, 8'h0, 8'h2, 8'h0};
        gseq.pop_front();
        check_seq("rr_sequence", seq_c);
        check("rr_regrant_m0", (gseq.size() > 4) ? 32'(gseq[4]) : 32'hF, 32'h1);
        s_dat_i = 16'h0000;
        repeat (3) tick();

        // Master 0 holds cyc for three transfers; no preemption.
        rst_pulse();
        fork
            xfer(0, 1'b1, 3'd5, 16'hC0DE, 3, rd0, ak0, ok0);
            begin
                tick();
                xfer(1, 1'b1, 3'd6, 16'hF00D, 1, rd1, ak1, ok1);
            end
            watch(24);
        join
        check("hold_m0_done", 32'(ok0), 1);
        check("hold_m1_done", 32'(ok1), 1);
        seq_d = '{8'h0, 8'h1, 8'h0, 8'h2};
        check_seq("hold_sequence", seq_d);
        repeat (3) tick();

`ifdef PIT_WB_ARB_TIMEOUT_EN
        // Slave never acks: watchdog frees the bus.
        rst_pulse();
        slave_en = 1'b0;
        mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("wd_grant", 32'(grant_o), 32'h1);
            check("wd_no_err", 32'({m_err_o, s_stb_o}), 32'h1);
        end
        tick();
        check("wd_err", 32'(m_err_o), 32'h1);
        check("wd_stb_forced", 32'({s_cyc_o, s_stb_o}), 0);
        tick();
        mc[0] = 0; ms[0] = 0;
        check("wd_idle", 32'(grant_o), 0);
        tick();
        check("wd_next_m1", 32'(grant_o), 32'h2);
        check("wd_err_clear", 32'(m_err_o), 0);
        tick();
        mc[1] = 0; ms[1] = 0;
        slave_en = 1'b1;
        repeat (3) tick();
`endif

        // Synchronous reset during a master 1 grant.
        mc[1] = 1; ms[1] = 1;
        okw = 1'b0;
        for (int c = 0; c < 10 && !okw; c++) begin
            tick();
            if (grant_o == 2'b10) okw = 1'b1;
        end
        check("srst_m1_granted", 32'(okw), 1);
        wb_rst = 1'b1;
        tick();
        check("srst_grant", 32'(grant_o), 0);
        wb_rst = 1'b0;
        mc[0] = 1; ms[0] = 1;
        tick();
        check("srst_m0_first", 32'(grant_o), 32'h1);
        // Reset while master 0 owns the bus: last must return to N-1.
        wb_rst = 1'b1;
        tick();
        check("srst2_grant", 32'(grant_o), 0);
        wb_rst = 1'b0;
        tick();
        check("srst2_m0_first", 32'(grant_o), 32'h1);
        mc[0] = 0; ms[0] = 0; mc[1] = 0; ms[1] = 0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
